// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder built around one shared 4-bit slice.
// Each RUN cycle adds one nibble, LSB first, and chains the carry to the next.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int BW = IW + 2;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic             cout_q;
  logic             ovf_q;

  logic [BW-1:0] base;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    slice;
  logic [3:0]    s;
  logic          c;
  logic          last;
  logic          accept;

  // Nibble offset of the current step.
  assign base  = {idx, 2'b00};
  assign a_nib = a_q[base +: 4];
  assign b_nib = b_q[base +: 4];

  // Full 5-bit slice result; the carry is never dropped.
  assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  assign s     = slice[3:0];
  assign c     = slice[4];

  assign last   = (idx == LAST);
  assign accept = (state == IDLE) && in_valid;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      carry_q <= c;
      if (!last) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == RUN) begin
      sum_q[base +: 4] <= s;
      if (last) begin
        cout_q <= c;
        // Same-sign operands whose result sign differs.
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (s[3] != a_q[WIDTH-1]);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and back-to-back random checks for nibble_serial_adder_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int checks;
  int failures;
  int cyc;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv,
                          input logic cv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_ready", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    cin = 1'b1;
  endtask

  task automatic wait_done(input string tag,
                           input logic [WIDTH-1:0] es,
                           input logic ec,
                           input logic eo);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(NSLICE));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             eovf;
    int               n;
    int               prev;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    prev = 0;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_op(16'h1234, 16'h4321, 1'b0);
    check("run_busy", 32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    wait_done("t1", 16'h5555, 1'b0, 1'b0);
    consume("t1");

    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done("t2", 16'h0000, 1'b1, 1'b0);
    consume("t2");

    start_op(16'h7FFF, 16'h0000, 1'b1);
    wait_done("t3a", 16'h8000, 1'b0, 1'b1);
    consume("t3a");

    start_op(16'h8000, 16'h8000, 1'b0);
    wait_done("t3b", 16'h0000, 1'b1, 1'b1);

    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      a = 16'h1111;
      b = 16'h2222;
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h0000);
      check("bp_cout", 32'(cout), 32'd1);
      check("bp_ovf", 32'(ovf), 32'd1);
    end
    in_valid = 1'b0;
    consume("t4");

    start_op(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_done("t6", 16'h0002, 1'b0, 1'b0);
    consume("t6");

    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      if (i % 50 == 0) ra = 16'hFFFF;
      a = ra;
      b = rb;
      cin = rc;
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready", 32'(in_ready), 32'd1);
      if (i > 0) check("b2b_period", 32'(cyc - prev), 32'(NSLICE + 2));
      prev = cyc;
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      eovf = (ra[WIDTH-1] == rb[WIDTH-1]) &&
             (full[WIDTH-1] != ra[WIDTH-1]);
      check("b2b_sum", 32'(sum), 32'(full[WIDTH-1:0]));
      check("b2b_cout", 32'(cout), 32'(full[WIDTH]));
      check("b2b_ovf", 32'(ovf), 32'(eovf));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
